// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter plus req/ack instruction fetch into a single-entry decode buffer
module fetch_pc_unit #(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_pc_in,
    input  logic             redirect,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready
);
    typedef enum logic [1:0] {IDLE, REQ, FLUSH, HOLD} state_t;
    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pending_pc;
    logic             redirect_pending;
    assign pc_plus   = pc + WIDTH'(PC_STEP);
    assign imem_addr = pc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            pending_pc       <= RESET_PC;
            redirect_pending <= 1'b0;
            imem_req         <= 1'b0;
            instr            <= '0;
            instr_pc         <= '0;
            instr_valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) pc <= next_pc_in;
                    imem_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    if (imem_ack && redirect) begin
                        pc <= next_pc_in;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc_plus;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end else if (redirect) begin
                        pending_pc       <= next_pc_in;
                        redirect_pending <= 1'b1;
                        state            <= FLUSH;
                    end
                end
                FLUSH: begin
                    // the outstanding request must complete before the new address goes out
                    if (imem_ack) begin
                        if (redirect) pc <= next_pc_in;
                        else if (redirect_pending) pc <= pending_pc;
                        redirect_pending <= 1'b0;
                        state            <= REQ;
                    end else if (redirect) begin
                        pending_pc <= next_pc_in;
                    end
                end
                HOLD: begin
                    if (redirect || instr_ready) begin
                        if (redirect) pc <= next_pc_in;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
